// File: rtl/dmem_pkg.sv
// Shared constants and types for the data memory with optional store buffer.
// The store buffer is built only when DMEM_STORE_BUF_EN is defined.
package dmem_pkg;

  localparam int DMEM_W        = 32;
  localparam int DMEM_AW       = 10;
  localparam int DMEM_SB_DEPTH = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [DMEM_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    SB_EMPTY   = 2'd0,
    SB_PARTIAL = 2'd1,
    SB_FULL    = 2'd2
  } sb_state_e;

endpackage

// File: rtl/dmem_if.sv
// Load/store port bundle between the mem stage (master) and dmem (slave).
interface dmem_if #(
  parameter int W = 32
);
  logic         load_en;
  logic [W-1:0] l_addr;
  logic [W-1:0] l_data;
  logic         store_en;
  logic [W-1:0] s_addr;
  logic [W-1:0] s_data;
  logic         sb_full;
  logic         addr_err;

  modport master (
    output load_en, l_addr, store_en, s_addr, s_data,
    input  l_data, sb_full, addr_err
  );

  modport slave (
    input  load_en, l_addr, store_en, s_addr, s_data,
    output l_data, sb_full, addr_err
  );
endinterface

// File: rtl/dmem_store_buf.sv
// Circular store buffer with youngest-match load forwarding.
// Instantiated by dmem only when DMEM_STORE_BUF_EN is defined.
module dmem_store_buf
  import dmem_pkg::*;
#(
  parameter int W        = DMEM_W,
  parameter int AW       = DMEM_AW,
  parameter int SB_DEPTH = DMEM_SB_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_i,
  input  logic [AW-1:0] enq_idx_i,
  input  logic [W-1:0]  enq_data_i,
  input  logic          deq_i,
  output logic [AW-1:0] head_idx_o,
  output logic [W-1:0]  head_data_o,
  output logic          full_o,
  output logic          empty_o,
  input  logic [AW-1:0] fwd_idx_i,
  output logic          fwd_hit_o,
  output logic [W-1:0]  fwd_data_o
);

  localparam int PW = $clog2(SB_DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  logic [AW-1:0]       idx_q  [SB_DEPTH];
  logic [W-1:0]        data_q [SB_DEPTH];
  logic [SB_DEPTH-1:0] vld_q;
  ptr_t                head_q, head_d, tail_q, tail_d, fwd_pos;
  cnt_t                count_q, count_d;
  sb_state_e           state_q, state_d;
  logic                do_enq, do_deq;

  // A dequeue in the same cycle frees the slot, so a store while full still lands.
  assign do_deq  = deq_i && !empty_o;
  assign do_enq  = enq_i && (!full_o || do_deq);

  assign full_o      = (state_q == SB_FULL);
  assign empty_o     = (state_q == SB_EMPTY);
  assign head_idx_o  = idx_q[head_q];
  assign head_data_o = data_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_deq) head_d = head_q + ptr_t'(1);
    if (do_enq) tail_d = tail_q + ptr_t'(1);
    case ({do_enq, do_deq})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_EMPTY: if (do_enq) state_d = SB_PARTIAL;
      SB_PARTIAL: begin
        if (do_enq && !do_deq && count_q == cnt_t'(SB_DEPTH - 1))
          state_d = SB_FULL;
        else if (do_deq && !do_enq && count_q == cnt_t'(1))
          state_d = SB_EMPTY;
      end
      SB_FULL: if (do_deq && !do_enq) state_d = SB_PARTIAL;
      default: state_d = SB_EMPTY;
    endcase
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    fwd_pos    = head_q;
    for (int k = 0; k < SB_DEPTH; k++) begin
      fwd_pos = head_q + ptr_t'(k);
      if (vld_q[fwd_pos] && idx_q[fwd_pos] == fwd_idx_i) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[fwd_pos];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SB_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // When full, head == tail: the set below must win over the clear.
      if (do_deq) vld_q[head_q] <= 1'b0;
      if (do_enq) vld_q[tail_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq && !rst) begin
      idx_q[tail_q]  <= enq_idx_i;
      data_q[tail_q] <= enq_data_i;
    end
  end

endmodule

// File: rtl/dmem.sv
// Word-addressed data RAM with range checking and an optional store buffer.
// Define DMEM_STORE_BUF_EN to build the buffer; otherwise stores write through.
module dmem
  import dmem_pkg::*;
#(
  parameter int W        = DMEM_W,
  parameter int AW       = DMEM_AW,
  parameter int SB_DEPTH = DMEM_SB_DEPTH
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);

  if (W <= AW + 2) begin : g_bad_w
    $error("dmem: W must exceed AW+2");
  end
  if (SB_DEPTH < 2 || (SB_DEPTH & (SB_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dmem: SB_DEPTH must be a power of two >= 2");
  end

  logic [W-1:0]  ram_q [2**AW];
  logic [AW-1:0] l_idx, s_idx, ram_widx;
  logic [W-1:0]  ram_rd, ram_wdata, l_word;
  logic          l_oor, s_oor, st_ok, ram_we;
  logic          addr_err_q, addr_err_d;
  logic          unused_addr_lsbs;

  assign l_idx = bus.l_addr[AW+1:2];
  assign s_idx = bus.s_addr[AW+1:2];
  assign l_oor = |bus.l_addr[W-1:AW+2];
  assign s_oor = |bus.s_addr[W-1:AW+2];
  assign unused_addr_lsbs = ^{bus.l_addr[1:0], bus.s_addr[1:0]};

  assign st_ok      = bus.store_en && !s_oor && !rst;
  assign ram_rd     = ram_q[l_idx];
  assign addr_err_d = (bus.load_en && l_oor) || (bus.store_en && s_oor);

`ifdef DMEM_STORE_BUF_EN
  logic          sb_deq, sb_full, sb_empty, fwd_hit;
  logic [AW-1:0] head_idx;
  logic [W-1:0]  head_data, fwd_data;

  // Drain whenever the load port is idle, or forcibly when the buffer is full.
  assign sb_deq = !rst && !sb_empty && (!bus.load_en || sb_full);

  dmem_store_buf #(
    .W        (W),
    .AW       (AW),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .enq_i       (st_ok),
    .enq_idx_i   (s_idx),
    .enq_data_i  (bus.s_data),
    .deq_i       (sb_deq),
    .head_idx_o  (head_idx),
    .head_data_o (head_data),
    .full_o      (sb_full),
    .empty_o     (sb_empty),
    .fwd_idx_i   (l_idx),
    .fwd_hit_o   (fwd_hit),
    .fwd_data_o  (fwd_data)
  );

  assign ram_we      = sb_deq;
  assign ram_widx    = head_idx;
  assign ram_wdata   = head_data;
  assign l_word      = fwd_hit ? fwd_data : ram_rd;
  assign bus.sb_full = sb_full;
`else
  assign ram_we      = st_ok;
  assign ram_widx    = s_idx;
  assign ram_wdata   = bus.s_data;
  assign l_word      = ram_rd;
  assign bus.sb_full = FALSE;
`endif

  assign bus.l_data   = (bus.load_en && !l_oor) ? l_word : '0;
  assign bus.addr_err = addr_err_q;

  always_ff @(posedge clk) begin
    if (rst) addr_err_q <= 1'b0;
    else     addr_err_q <= addr_err_d;
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_widx] <= ram_wdata;
  end

endmodule

// File: tb/tb_dmem.sv
// Directed bench for dmem; expectations follow DMEM_STORE_BUF_EN when defined.
module tb_dmem;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_if #(.W(32)) bus ();

  dmem #(.W(32), .AW(10), .SB_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef DMEM_STORE_BUF_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  typedef struct packed {
    logic        le;
    logic [31:0] la;
    logic        se;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [31:0] exp_ld;
    logic        exp_full;
    logic        exp_err;
  } vec_t;

  localparam int NV = 18;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic le, input logic [31:0] la, input logic se,
                       input logic [31:0] sa, input logic [31:0] sd);
    bus.load_en  = le;
    bus.l_addr   = la;
    bus.store_en = se;
    bus.s_addr   = sa;
    bus.s_data   = sd;
  endtask

  initial begin
    //        le    la             se    sa             sd             exp_ld         full  err
    vec[0]  = '{1'b0, 32'h0,        1'b1, 32'h100,      32'hDEAD0001, 32'h0,        1'b0, 1'b0};
    vec[1]  = '{1'b1, 32'h100,      1'b0, 32'h0,        32'h0,        32'hDEAD0001, 1'b0, 1'b0};
    vec[2]  = '{1'b1, 32'h103,      1'b0, 32'h0,        32'h0,        32'hDEAD0001, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 32'h100,      1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
    vec[4]  = '{1'b1, 32'h100,      1'b0, 32'h0,        32'h0,        32'hDEAD0001, 1'b0, 1'b0};
    vec[5]  = '{1'b1, 32'h00010000, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
    vec[6]  = '{1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
    vec[7]  = '{1'b0, 32'h0,        1'b1, 32'h00010100, 32'h00000BAD, 32'h0,        1'b0, 1'b1};
    vec[8]  = '{1'b1, 32'h100,      1'b0, 32'h0,        32'h0,        32'hDEAD0001, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 32'h0,        1'b1, 32'hFFC,      32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
    vec[10] = '{1'b1, 32'hFFC,      1'b0, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0, 1'b0};
    vec[11] = '{1'b1, 32'h1000,     1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
    vec[12] = '{1'b0, 32'h0,        1'b1, 32'h20,       32'hA,        32'h0,        1'b0, 1'b0};
    vec[13] = '{1'b1, 32'h100,      1'b1, 32'h20,       32'hB,        32'hDEAD0001, 1'b0, 1'b0};
    vec[14] = '{1'b1, 32'h22,       1'b0, 32'h0,        32'h0,        32'hB,        1'b0, 1'b0};
    vec[15] = '{1'b1, 32'h20,       1'b1, 32'h20,       32'hC,        32'hB,        1'b0, 1'b0};
    vec[16] = '{1'b1, 32'h20,       1'b0, 32'h0,        32'h0,        32'hC,        1'b0, 1'b0};
    vec[17] = '{1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};

    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 32'h00010000, 32'h1);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("reset_sb_full", 32'(bus.sb_full), 32'h0);
    chk("reset_addr_err", 32'(bus.addr_err), 32'h0);
    chk("reset_l_data", bus.l_data, 32'h0);

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].le, vec[i].la, vec[i].se, vec[i].sa, vec[i].sd);
      #1;
      chk($sformatf("v%0d_l_data", i), bus.l_data, vec[i].exp_ld);
      tick();
      chk($sformatf("v%0d_sb_full", i), 32'(bus.sb_full), 32'(vec[i].exp_full));
      chk($sformatf("v%0d_addr_err", i), 32'(bus.addr_err), 32'(vec[i].exp_err));
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    repeat (5) tick();

    // Store buffered while load_en is held; RAM only updates once loads stop.
    drive(1'b0, 32'h0, 1'b1, 32'h10, 32'h55);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    drive(1'b1, 32'h10, 1'b1, 32'h10, 32'h11223344);
    tick();
    bus.store_en = 1'b0;
    #1;
    chk("s33_l_data", bus.l_data, 32'h11223344);
    chk("s33_ram_after_store", dut.ram_q[4], SB ? 32'h55 : 32'h11223344);
    chk("s33_sb_full", 32'(bus.sb_full), 32'h0);
    tick();
    chk("s33_ram_held", dut.ram_q[4], SB ? 32'h55 : 32'h11223344);
    bus.load_en = 1'b0;
    tick();
    chk("s33_ram_drained", dut.ram_q[4], 32'h11223344);

    // Five back-to-back stores with loads pending: fill, then forced drain.
    bus.load_en = 1'b1;
    bus.l_addr  = 32'h10;
    for (int k = 0; k < 5; k++) begin
      bus.store_en = 1'b1;
      bus.s_addr   = 32'h200 + 32'(4 * k);
      bus.s_data   = 32'h50 + 32'(k);
      tick();
      chk($sformatf("s35_sb_full_%0d", k), 32'(bus.sb_full), 32'(SB && k >= 3));
    end
    bus.store_en = 1'b0;
    #1;
    chk("s35_forced_drain_ram", dut.ram_q[128], 32'h50);
    for (int k = 0; k < 5; k++) begin
      bus.l_addr = 32'h200 + 32'(4 * k);
      #1;
      chk($sformatf("s35_readback_%0d", k), bus.l_data, 32'h50 + 32'(k));
    end
    bus.load_en = 1'b0;
    repeat (5) tick();
    chk("s35_drained_sb_full", 32'(bus.sb_full), 32'h0);

    // Reset with three stores pending discards them; RAM keeps old data.
    drive(1'b0, 32'h0, 1'b1, 32'h300, 32'h77);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    bus.load_en = 1'b1;
    bus.l_addr  = 32'h10;
    for (int k = 0; k < 3; k++) begin
      bus.store_en = 1'b1;
      bus.s_addr   = 32'h300 + 32'(4 * k);
      bus.s_data   = 32'h88 + 32'(k * 17);
      tick();
    end
    rst = 1'b1;
    bus.s_addr = 32'h00010000;
    bus.s_data = 32'hEE;
    tick();
    rst = 1'b0;
    bus.store_en = 1'b0;
    #1;
    chk("s37_sb_full", 32'(bus.sb_full), 32'h0);
    chk("s37_addr_err", 32'(bus.addr_err), 32'h0);
    bus.l_addr = 32'h300;
    #1;
    chk("s37_l_data", bus.l_data, SB ? 32'h77 : 32'h88);
    bus.l_addr = 32'h100;
    #1;
    chk("s37_ram_kept", bus.l_data, 32'hDEAD0001);
    tick();
    chk("s37_sb_full_after", 32'(bus.sb_full), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
